lut_row_streamer: RTL and testbench
===================================

Name: lut_row_streamer

Overview:
Reader/consumer for the 28×36-bit pattern lookup ROM (combinational, 5-bit address, 36-bit word). On a start request it walks a contiguous run of ROM rows and streams each row as six 6-bit fields to a downstream drawing or consumer stage over a valid/ready handshake. It sits between the game/control FSM, which selects a pattern page (base row and row count), and the pixel/sprite logic that consumes fields.

Parameters:
ROM_DEPTH, 28, number of valid ROM rows; addresses ≥ ROM_DEPTH are illegal.
FIELD_W, 6, width of one streamed field.
FIELDS_PER_ROW, 6, fields per 36-bit row (FIELD_W*FIELDS_PER_ROW = 36).

Ports:
Clk  in  1  system clock, all state on rising edge.
Reset_n  in  1  asynchronous, active-low reset.
start  in  1  request pulse, sampled only in IDLE.
base_addr  in  5  first ROM row of the run.
row_count  in  5  number of rows to stream (0 legal).
busy  out  1  high from accepted start until done.
err  out  1  one-cycle pulse on a rejected request.
done  out  1  one-cycle pulse when the run completes.
rom_addr  out  5  address to the ROM.
rom_data  in  36  ROM word (combinational from rom_addr).
field  out  6  current field; field 0 = rom_data[35:30], MSB first.
field_valid  out  1  field/row_idx/field_idx/last are valid.
field_ready  in  1  consumer accepts when valid && ready.
row_idx  out  5  row offset within the run (0-based).
field_idx  out  3  0..5 within the row.
last  out  1  high on field 5 of the final row.

Behaviour:
- Reset (async, Reset_n=0): state IDLE; busy, err, done, field_valid and last are 0; field, row_idx, field_idx and rom_addr are 0; row buffer is cleared. A reset asserted mid-run aborts immediately with no done pulse.
- States: IDLE, FETCH, SHIFT, DONE.
- IDLE: on start=1:
  - If base_addr + row_count > ROM_DEPTH (6-bit compare, no wrap), pulse err for 1 cycle and stay IDLE.
  - Else if row_count=0, go to DONE.
  - Else latch base/count, set row_idx=0 and go to FETCH. busy rises the cycle after start.
- FETCH (exactly 1 cycle): drive rom_addr = base + row_idx. Register rom_data into the 36-bit row buffer at the clock edge. Go to SHIFT with field_idx=0.
- SHIFT: field_valid=1; field = buffer[35-6*field_idx -: 6]. field is held stable while valid && !ready.
  - On handshake with field_idx<5: field_idx++.
  - On handshake with field_idx=5 and row_idx<count-1: row_idx++, go to FETCH. There is one bubble cycle per row, with field_valid=0 in FETCH.
  - On handshake with field_idx=5 and final row: go to DONE.
- DONE: done=1 and busy=0 for 1 cycle, then IDLE.
- start is ignored while busy or in DONE.
- rom_addr holds its last value outside FETCH.
- Latency: first field_valid appears 2 cycles after the start edge. Full-throughput run time is count*7 cycles plus 2.
- last = field_valid && field_idx=5 && row_idx=count-1.
- No wrap-around past ROM_DEPTH-1 is possible because of the range check.
- field_ready while field_valid=0 has no effect.

Decomposition:
- Shared package (lut_pkg): ROM_DEPTH, FIELD_W, FIELDS_PER_ROW, ADDR_W=5, ROW_W=36, and the state enum typedef (IDLE, FETCH, SHIFT, DONE).
- One natural sub-module: row_field_shifter. It holds the 36-bit buffer plus the field_idx counter, exposes load/advance inputs, and provides field/field_idx/last_field outputs.
- The top level keeps the FSM, range check and row counter, and instantiates the ROM externally.

Test Plan:
1. Reset_n=0 mid-SHIFT on row 1 → next edge all outputs 0, state IDLE, no done pulse. After release, start base=0,count=1 streams normally.
2. start base=0, count=1, field_ready=1 → fields 0x06,0x24,0x19,0x26,0x24,0x19 on consecutive cycles starting 2 cycles after start. last on 0x19 (field 5), done 1 cycle later, busy low with done.
3. start base=3, count=2, ready=1 → row 3 fields 0x16,0x16,0x08,0x16,0x16,0x0A; FETCH bubble; row 4 fields 0x06,0x16,0x18,0x16,0x16,0x0A; row_idx 0 then 1.
4. Backpressure: base=0,count=1 with ready toggling 1,0,0,1,... → field holds value and field_idx frozen during ready=0; exactly 6 handshakes, no duplicates or drops.
5. Range/zero: base=25,count=4 → err pulse, busy stays 0. base=27,count=1 → accepted, streams row 27. count=0 → done 1 cycle after start, no field_valid.
6. start asserted again during SHIFT with base=10 → ignored; rom_addr never equals 10; run completes with original rows.

Source files
------------

// File: rtl/lut_pkg.sv
// Shared sizes and FSM state type for the pattern ROM row streamer.
package lut_pkg;

    localparam int ROM_DEPTH      = 28;
    localparam int FIELD_W        = 6;
    localparam int FIELDS_PER_ROW = 6;
    localparam int ADDR_W         = 5;
    localparam int IDX_W          = 3;
    localparam int ROW_W          = FIELD_W * FIELDS_PER_ROW;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        SHIFT,
        DONE
    } state_t;

endpackage

// File: rtl/row_field_shifter.sv
// Holds one ROM row and presents it MSB-first, one field at a time.
module row_field_shifter
    import lut_pkg::*;
(
    input  logic               Clk,
    input  logic               Reset_n,
    input  logic               load,
    input  logic               advance,
    input  logic [ROW_W-1:0]   row_data,
    output logic [FIELD_W-1:0] field,
    output logic [IDX_W-1:0]   field_idx,
    output logic               last_field
);

    logic [ROW_W-1:0] row_q;
    logic [ROW_W-1:0] shifted;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            row_q     <= '0;
            field_idx <= '0;
        end else if (load) begin
            row_q     <= row_data;
            field_idx <= '0;
        end else if (advance && !last_field) begin
            field_idx <= field_idx + 3'd1;
        end
    end

    // Field 0 sits in the top bits, so shift the selected field up to the MSBs.
    always_comb begin
        shifted    = row_q << (FIELD_W * int'(field_idx));
        field      = shifted[ROW_W-1 -: FIELD_W];
        last_field = (field_idx == IDX_W'(FIELDS_PER_ROW - 1));
    end

endmodule

// File: rtl/lut_row_streamer.sv
// Walks a contiguous run of pattern ROM rows and streams each as six fields.
module lut_row_streamer
    import lut_pkg::*;
(
    input  logic               Clk,
    input  logic               Reset_n,
    input  logic               start,
    input  logic [ADDR_W-1:0]  base_addr,
    input  logic [ADDR_W-1:0]  row_count,
    output logic               busy,
    output logic               err,
    output logic               done,
    output logic [ADDR_W-1:0]  rom_addr,
    input  logic [ROW_W-1:0]   rom_data,
    output logic [FIELD_W-1:0] field,
    output logic               field_valid,
    input  logic               field_ready,
    output logic [ADDR_W-1:0]  row_idx,
    output logic [IDX_W-1:0]   field_idx,
    output logic               last
);

    state_t            state;
    state_t            state_nx;
    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W-1:0] count_q;
    logic [ADDR_W:0]   span;
    logic              bad_req;
    logic              accept;
    logic              hs;
    logic              last_field;
    logic              final_row;

    // Widened by one bit so base+count cannot wrap past the ROM end.
    assign span      = {1'b0, base_addr} + {1'b0, row_count};
    assign bad_req   = span > (ADDR_W+1)'(ROM_DEPTH);
    assign accept    = (state == IDLE) && start && !bad_req;
    assign hs        = field_valid && field_ready;
    assign final_row = (row_idx == count_q - 5'd1);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_nx = (row_count == '0) ? DONE : FETCH;
                end
            end
            FETCH: state_nx = SHIFT;
            SHIFT: begin
                if (hs && last_field) begin
                    state_nx = final_row ? DONE : FETCH;
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy        = (state == FETCH) || (state == SHIFT);
        done        = (state == DONE);
        field_valid = (state == SHIFT);
        last        = field_valid && last_field && final_row;
    end

    // rom_addr is set up one edge ahead so it is stable for the whole FETCH cycle.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            err      <= 1'b0;
            base_q   <= '0;
            count_q  <= '0;
            row_idx  <= '0;
            rom_addr <= '0;
        end else begin
            err <= (state == IDLE) && start && bad_req;
            if (accept && (row_count != '0)) begin
                base_q   <= base_addr;
                count_q  <= row_count;
                row_idx  <= '0;
                rom_addr <= base_addr;
            end else if ((state == SHIFT) && hs && last_field && !final_row) begin
                row_idx  <= row_idx + 5'd1;
                rom_addr <= base_q + row_idx + 5'd1;
            end
        end
    end

    row_field_shifter u_shifter (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .load       (state == FETCH),
        .advance    (hs),
        .row_data   (rom_data),
        .field      (field),
        .field_idx  (field_idx),
        .last_field (last_field)
    );

endmodule

// File: tb/tb_lut_row_streamer.sv
// Randomized self-checking bench for lut_row_streamer with a behavioural ROM.
module tb_lut_row_streamer;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic        start;
    logic [4:0]  base_addr;
    logic [4:0]  row_count;
    logic        busy;
    logic        err;
    logic        done;
    logic [4:0]  rom_addr;
    logic [35:0] rom_data;
    logic [5:0]  field;
    logic        field_valid;
    logic        field_ready;
    logic [4:0]  row_idx;
    logic [2:0]  field_idx;
    logic        last;

    logic [35:0] rom [0:31];
    int          n_chk = 0;
    int          n_fail = 0;

    always #5 Clk = ~Clk;

    assign rom_data = (rom_addr < 5'd28) ? rom[rom_addr] : 36'h0;

    lut_row_streamer dut (
        .Clk         (Clk),
        .Reset_n     (Reset_n),
        .start       (start),
        .base_addr   (base_addr),
        .row_count   (row_count),
        .busy        (busy),
        .err         (err),
        .done        (done),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .field       (field),
        .field_valid (field_valid),
        .field_ready (field_ready),
        .row_idx     (row_idx),
        .field_idx   (field_idx),
        .last        (last)
    );

    // mode 0: always ready, 1: ready pattern 1,0,0, 2: random ready
    task automatic run(input logic [4:0] b, input logic [4:0] c,
                       input int mode, input bit inject);
        logic [5:0]  ef [$];
        logic [35:0] w;
        int          k = 0;
        int          cyc = 0;
        int          first = -1;
        int          total;
        bit          fin = 0;
        total = 6 * int'(c);
        for (int r = 0; r < int'(c); r++) begin
            w = rom[int'(b) + r];
            for (int f = 0; f < 6; f++)
                ef.push_back(6'(w >> (6 * (5 - f))));
        end
        @(negedge Clk);
        start = 1'b1;
        base_addr = b;
        row_count = c;
        field_ready = 1'b1;
        n_chk++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_busy: got %b want 0", busy);
        end
        while (!fin && cyc < 600) begin
            @(negedge Clk);
            cyc++;
            if (cyc == 1) begin
                start = inject;
                base_addr = inject ? 5'd10 : b;
                row_count = inject ? 5'd1 : c;
            end
            if (inject && cyc == 5) start = 1'b0;
            case (mode)
                0:       field_ready = 1'b1;
                1:       field_ready = (cyc >= 2) && ((cyc - 2) % 3 == 0);
                default: field_ready = 1'($urandom_range(0, 1));
            endcase
            n_chk++;
            if (err !== 1'b0) begin
                n_fail++;
                $display("FAIL run_err: got %b want 0", err);
            end
            if (inject) begin
                n_chk++;
                if (rom_addr === 5'd10) begin
                    n_fail++;
                    $display("FAIL ignored_start_addr: got %0d want not 10", rom_addr);
                end
            end
            if (done === 1'b1) begin
                fin = 1;
                n_chk++;
                if (busy !== 1'b0 || field_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL done_flags: busy %b valid %b want 0 0", busy, field_valid);
                end
                n_chk++;
                if (k != total) begin
                    n_fail++;
                    $display("FAIL handshake_count: got %0d want %0d", k, total);
                end
                if (mode == 0) begin
                    n_chk++;
                    if (cyc != 7 * int'(c) + 1) begin
                        n_fail++;
                        $display("FAIL done_cycle: got %0d want %0d", cyc, 7 * int'(c) + 1);
                    end
                end
            end else begin
                n_chk++;
                if (busy !== 1'b1) begin
                    n_fail++;
                    $display("FAIL run_busy: cyc %0d got %b want 1", cyc, busy);
                end
                if (field_valid === 1'b1) begin
                    if (first < 0) begin
                        first = cyc;
                        n_chk++;
                        if (first != 2) begin
                            n_fail++;
                            $display("FAIL first_valid: got cyc %0d want 2", first);
                        end
                    end
                    n_chk++;
                    if (k >= total) begin
                        n_fail++;
                        $display("FAIL extra_field: got %0h want none", field);
                    end else if (field !== ef[k] || row_idx !== 5'(k / 6) ||
                                 field_idx !== 3'(k % 6) ||
                                 last !== (k == total - 1)) begin
                        n_fail++;
                        $display("FAIL field_%0d: got f=%0h r=%0d i=%0d l=%b want f=%0h r=%0d i=%0d l=%b",
                                 k, field, row_idx, field_idx, last,
                                 ef[k], k / 6, k % 6, k == total - 1);
                    end
                    if (field_ready) k++;
                end else begin
                    n_chk++;
                    if (rom_addr !== 5'(int'(b) + k / 6)) begin
                        n_fail++;
                        $display("FAIL fetch_addr: got %0d want %0d", rom_addr, int'(b) + k / 6);
                    end
                end
            end
        end
        if (!fin) begin
            n_chk++;
            n_fail++;
            $display("FAIL run_timeout: got no done want done b=%0d c=%0d", b, c);
        end
        start = 1'b0;
        @(negedge Clk);
        n_chk++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL after_done: done %b busy %b want 0 0", done, busy);
        end
    endtask

    task automatic check_zero(input string tag);
        n_chk++;
        if ({busy, err, done, field_valid, last} !== 5'b0 ||
            field !== 6'h0 || row_idx !== 5'h0 ||
            field_idx !== 3'h0 || rom_addr !== 5'h0) begin
            n_fail++;
            $display("FAIL %s: got b%b e%b d%b v%b l%b f%0h r%0d i%0d a%0d want all 0",
                     tag, busy, err, done, field_valid, last,
                     field, row_idx, field_idx, rom_addr);
        end
    endtask

    task automatic test_reset();
        #23;
        check_zero("reset_state");
        @(negedge Clk);
        Reset_n = 1'b1;
    endtask

    task automatic test_midrun_reset();
        int n = 0;
        @(negedge Clk);
        start = 1'b1;
        base_addr = 5'd3;
        row_count = 5'd2;
        field_ready = 1'b1;
        @(negedge Clk);
        start = 1'b0;
        while (!(field_valid === 1'b1 && row_idx === 5'd1) && n < 50) begin
            @(negedge Clk);
            n++;
        end
        n_chk++;
        if (n >= 50) begin
            n_fail++;
            $display("FAIL reach_row1: got timeout want row 1 shift");
        end
        Reset_n = 1'b0;
        #1;
        check_zero("midrun_reset");
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            n_chk++;
            if (done !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_done: got %b want 0", done);
            end
        end
        Reset_n = 1'b1;
        run(5'd0, 5'd1, 0, 0);
    endtask

    task automatic test_range();
        logic [4:0] b;
        logic [4:0] c;
        for (int t = 0; t < 10; t++) begin
            b = (t == 0) ? 5'd25 : 5'($urandom_range(0, 31));
            c = (t == 0) ? 5'd4  : 5'($urandom_range(0, 31));
            if (int'(b) + int'(c) > 28) begin
                @(negedge Clk);
                start = 1'b1;
                base_addr = b;
                row_count = c;
                @(negedge Clk);
                start = 1'b0;
                n_chk++;
                if (err !== 1'b1 || busy !== 1'b0) begin
                    n_fail++;
                    $display("FAIL err_pulse b=%0d c=%0d: err %b busy %b want 1 0", b, c, err, busy);
                end
                @(negedge Clk);
                n_chk++;
                if (err !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
                    n_fail++;
                    $display("FAIL err_one_cycle: err %b busy %b done %b want 0 0 0", err, busy, done);
                end
            end else begin
                run(b, c, 2, 0);
            end
        end
    endtask

    initial begin
        Reset_n = 1'b0;
        start = 1'b0;
        base_addr = '0;
        row_count = '0;
        field_ready = 1'b0;
        for (int i = 0; i < 32; i++)
            rom[i] = {4'($urandom), $urandom};
        rom[0] = {6'h06, 6'h24, 6'h19, 6'h26, 6'h24, 6'h19};
        rom[3] = {6'h16, 6'h16, 6'h08, 6'h16, 6'h16, 6'h0A};
        rom[4] = {6'h06, 6'h16, 6'h18, 6'h16, 6'h16, 6'h0A};
        test_reset();
        test_midrun_reset();
        run(5'd0, 5'd1, 0, 0);
        run(5'd3, 5'd2, 0, 0);
        run(5'd0, 5'd1, 1, 0);
        run(5'd27, 5'd1, 0, 0);
        run(5'd5, 5'd0, 0, 0);
        run(5'd0, 5'd2, 0, 1);
        test_range();
        run(5'd0, 5'd28, 2, 0);
        run(5'd12, 5'd3, 1, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
